// File: rtl/qr_sequencer.sv
// rtl/qr_sequencer.sv - Gram-Schmidt QR stage sequencer; watchdog enabled by QR_SEQ_TIMEOUT_EN
//
// Walks columns j and prior columns k<j, running DOT/MUL/SUB per (j,k) pair and
// NORM once per column. Each stage holds its stop latched until it sees its
// clear pulse, so every stage run ends with a one-cycle CLR state.
// Build option: define QR_SEQ_TIMEOUT_EN to add a per-stage watchdog (TIMEOUT
// cycles) that ends the run in ERR with a sticky err flag.
module qr_sequencer #(
  parameter int N       = 3,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       abort,
  output logic [3:0] stage_start,
  input  logic [3:0] stage_stop,
  output logic [3:0] stage_clr,
  output logic [1:0] col_idx,
  output logic [1:0] proj_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_ALL,
    S_DOT,
    S_CLR_DOT,
    S_MUL,
    S_CLR_MUL,
    S_SUB,
    S_CLR_SUB,
    S_NORM,
    S_CLR_NORM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] START_DOT  = 4'b0001;
  localparam logic [3:0] START_MUL  = 4'b0010;
  localparam logic [3:0] START_SUB  = 4'b0100;
  localparam logic [3:0] START_NORM = 4'b1000;
  localparam logic [3:0] CLR_EVERY  = 4'b1111;
  localparam logic [2:0] N_W        = 3'(N);

  state_t state;

  // col_idx is j and proj_idx is k; k is loaded with j on entry to NORM.
  logic [1:0] j;
  logic [1:0] k;

  assign col_idx  = j;
  assign proj_idx = k;

`ifdef QR_SEQ_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd;
`else
  // Without the watchdog a stage may stall forever and ERR is never entered.
  assign err = 1'b0;
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_unused
  end
`endif

  // Sequencer FSM: state, indices and every output are registered together so
  // that each output is a pure function of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      stage_start <= '0;
      stage_clr   <= '0;
      j           <= '0;
      k           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef QR_SEQ_TIMEOUT_EN
      err         <= 1'b0;
      wd          <= '0;
`endif
    end else begin
      stage_clr <= '0;
      done      <= 1'b0;
`ifdef QR_SEQ_TIMEOUT_EN
      // Only the stall path below keeps counting; any state change restarts it.
      wd        <= '0;
`endif
      if (abort && state != S_IDLE) begin
        state       <= S_IDLE;
        stage_start <= '0;
        stage_clr   <= CLR_EVERY;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go && !abort) begin
              state     <= S_CLR_ALL;
              stage_clr <= CLR_EVERY;
              busy      <= 1'b1;
              j         <= '0;
              k         <= '0;
`ifdef QR_SEQ_TIMEOUT_EN
              err       <= 1'b0;
`endif
            end
          end

          // Column 0 has no earlier columns to project out, so it goes straight to NORM.
          S_CLR_ALL: begin
            if (j == 2'd0) begin
              state       <= S_NORM;
              stage_start <= START_NORM;
            end else begin
              state       <= S_DOT;
              stage_start <= START_DOT;
            end
          end

          // The held start bit is exactly the active stage, so masking stop with
          // it ignores every other stage's stop and names the bit to clear.
          S_DOT, S_MUL, S_SUB, S_NORM: begin
            if ((stage_stop & stage_start) != 4'b0000) begin
              stage_start <= '0;
              stage_clr   <= stage_start;
              case (state)
                S_DOT:   state <= S_CLR_DOT;
                S_MUL:   state <= S_CLR_MUL;
                S_SUB:   state <= S_CLR_SUB;
                default: state <= S_CLR_NORM;
              endcase
            end
`ifdef QR_SEQ_TIMEOUT_EN
            else if (wd == WD_LAST) begin
              state       <= S_ERR;
              stage_start <= '0;
              stage_clr   <= CLR_EVERY;
              busy        <= 1'b0;
              err         <= 1'b1;
            end else begin
              wd <= wd + 8'd1;
            end
`endif
          end

          S_CLR_DOT: begin
            state       <= S_MUL;
            stage_start <= START_MUL;
          end

          S_CLR_MUL: begin
            state       <= S_SUB;
            stage_start <= START_SUB;
          end

          S_CLR_SUB: begin
            if ({1'b0, k} + 3'd1 < {1'b0, j}) begin
              k           <= k + 2'd1;
              state       <= S_DOT;
              stage_start <= START_DOT;
            end else begin
              k           <= j;
              state       <= S_NORM;
              stage_start <= START_NORM;
            end
          end

          S_CLR_NORM: begin
            if ({1'b0, j} + 3'd1 < N_W) begin
              j           <= j + 2'd1;
              k           <= '0;
              state       <= S_DOT;
              stage_start <= START_DOT;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end

          S_DONE: state <= S_IDLE;

          S_ERR: state <= S_IDLE;

          default: begin
            state       <= S_IDLE;
            stage_start <= '0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/qr_sequencer.md
# qr_sequencer

Control FSM for one Gram-Schmidt QR decomposition of an N×N matrix. It drives the start/stop handshakes of the four datapath stages in order: dot product, projection multiply, subtract, normalize. It iterates over columns j and prior columns k<j, then signals completion. It also owns the per-stage clear pulses, because each stage holds `stop` latched until its own reset.

## Interface
Parameters:
- `N`, default 3: matrix dimension; legal range 2..4.
- `TIMEOUT`, default 64: maximum cycles to wait for a stage `stop` (used only with `QR_SEQ_TIMEOUT_EN`); legal range 2..255.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `go`, in, 1: start one decomposition; sampled only in IDLE.
- `abort`, in, 1: cancel the run; honoured in any state.
- `stage_start`, out, 4: level start for each stage; bit 0 dot, 1 mul, 2 sub, 3 norm.
- `stage_stop`, in, 4: stop from each stage, same bit order.
- `stage_clr`, out, 4: one-cycle active-high clear to each stage's `reset`.
- `col_idx`, out, 2: current column j.
- `proj_idx`, out, 2: current projection column k; equals j during NORM.
- `busy`, out, 1: high from CLR_ALL through the last CLR state.
- `done`, out, 1: one-cycle pulse when the run finishes.
- `err`, out, 1: sticky timeout flag.

## Operation
- States: IDLE, CLR_ALL, DOT, CLR_DOT, MUL, CLR_MUL, SUB, CLR_SUB, NORM, CLR_NORM, DONE, ERR.
- IDLE:
  - `go`=1 and `abort`=0 → CLR_ALL; latch j=0, k=0.
  - `go` in any other state is ignored.
- CLR_ALL: `stage_clr`=4'b1111 for one cycle. Then go to NORM if j=0, else DOT.
- Stage states (DOT/MUL/SUB/NORM):
  - Hold the matching `stage_start` bit high.
  - Sample the matching `stage_stop` bit every cycle; the other `stop` bits are ignored.
  - When `stop` is seen, go to the matching CLR state on the next edge.
- CLR_x: `stage_start`=0, the matching `stage_clr` bit =1 for one cycle. Next state:
  - CLR_DOT → MUL.
  - CLR_MUL → SUB.
  - CLR_SUB: k+1<j → k++, DOT; else → NORM.
  - CLR_NORM: j+1<N → j++, k=0, then DOT. Otherwise → DONE.
- DONE: `done`=1 for one cycle, then IDLE. `col_idx` and `proj_idx` hold their last values.
- Stage order per column j: (DOT, MUL, SUB) repeated j times, then NORM. For N=3 that is 12 stage runs.
- `abort` in any non-IDLE state → next cycle `stage_clr`=4'b1111, all `stage_start`=0, state IDLE, no `done`. `abort` takes priority over `go`, `stop` and timeout in the same cycle.
- Index counters are 2-bit; j and k never exceed N-1, so there is no wrap.

## Timing
- Reset values: `stage_start`=0, `stage_clr`=0, `col_idx`=0, `proj_idx`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- Reset asserted mid-run: the outputs above apply on the next edge. No clear pulse is issued; the stages are expected to share the system reset.
- All outputs are registered and Moore-decoded from state. There is no combinational path from `stage_stop` to `stage_start`.
- `go` sampled at edge 0:
  - CLR_ALL occupies cycle 1.
  - The first stage start is high in cycle 2.
- Cost per stage run: the stage's own cycles in the start state, plus 1 CLR cycle.
- Stub stages that raise `stop` on their 2nd start cycle give 3 cycles per run. For N=3, `done` is then high in cycle 38.
- A `stop` already high on entry to a stage state advances it after one cycle. Clearing `stop` is guaranteed by the CLR states.

## Configuration
- `QR_SEQ_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles spent in the current stage state with its `stop` low. It resets on every state change.
  - When the count reaches `TIMEOUT`, the next state is ERR.
  - ERR: `stage_clr`=4'b1111 for one cycle, `err`=1, `busy`=0, then IDLE.
  - `err` stays high until the next accepted `go` or until reset.
- `QR_SEQ_TIMEOUT_EN` not defined: there is no watchdog, `err` is tied 0, and ERR is unreachable. The FSM waits indefinitely for `stop`.

## Test plan
- Nominal run, N=3, stub stop on the 2nd start cycle → exactly 12 starts in order NORM(0,0); DOT/MUL/SUB(1,0); NORM(1,1); DOT/MUL/SUB(2,0); DOT/MUL/SUB(2,1); NORM(2,2). `done` pulses in cycle 38 and `busy` is high in cycles 1–37.
- Variable stub latency, 1–7 cycles per stage → same stage order; each `stage_clr` pulse follows its `stop` by exactly 1 cycle.
- `abort` during the second SUB (j=2, k=1) → next cycle `stage_clr`=4'b1111, then IDLE with no `done`. A following `go` restarts at j=0.
- `go` and `abort` high in the same IDLE cycle → stays IDLE. `go` pulses while busy → ignored.
- With `QR_SEQ_TIMEOUT_EN` and `TIMEOUT`=10, the MUL stub never stops → ERR after 10 cycles in MUL; `err`=1 sticky, `stage_clr`=4'b1111, `busy`=0. A new `go` clears `err`.
- `reset`=0 asserted during NORM(1,1) → all outputs 0 on the next edge. After `reset` returns to 1, a `go` runs a full, correct sequence.
